seq_mult_stage: RTL and testbench

- Iterative shift-add multiplier that produces the truncated product feeding the LUT/decode stage directly downstream.
- That stage consumes `(signal_0 * signal_1) mod 2^WIDTH`. This block computes it over multiple cycles to avoid a full-width combinational multiplier.
- Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake.

---
 rtl/seq_mult_stage.sv | 87 ++++++++
 tb/tb_seq_mult_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_stage.sv
// Iterative shift-add multiplier producing (signal_0 * signal_1) mod 2^WIDTH.
// Consumes STEP multiplier bits per cycle; operands and product use valid/ready handshakes.
module seq_mult_stage #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] signal_0,
  input  logic [WIDTH-1:0] signal_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) || (WIDTH % STEP != 0)) begin : g_bad_param
    $error("seq_mult_stage: STEP must be 1, 2, 4 or 8 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, acc, partial;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;

  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  // Gated by rst_n so in_ready stays low while reset is held, even though state reads IDLE.
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  // Partial product a * b[STEP-1:0] built from shifted copies of a; bits shifted past WIDTH drop out.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (b[i]) partial = partial + (a << i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (accept) begin
        a   <= signal_0;
        b   <= signal_1;
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc + partial;
        a   <= a << STEP;
        b   <= b >> STEP;
        cnt <= cnt + 1'b1;
        // product only changes on entry to DONE, so it holds the last delivered result otherwise.
        if (last) product <= acc + partial;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_stage.sv
// Scoreboard bench for seq_mult_stage: STEP=1 and STEP=4 instances checked against a 64-bit
// arithmetic reference, with latency, backpressure, overlap and mid-operation reset scenarios.
module tb_seq_mult_stage;

  localparam int W  = 32;
  localparam int N1 = 32;
  localparam int N4 = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [W-1:0] signal_0 = '0, signal_1 = '0, product;
  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, busy4;
  logic [W-1:0] s0_4 = '0, s1_4 = '0, product4;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] exp;
    int           acc_edge;
  } item_t;

  item_t sb[$];
  item_t sb4[$];

  seq_mult_stage #(.WIDTH(W), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signal_0(signal_0), .signal_1(signal_1), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_mult_stage #(.WIDTH(W), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .signal_0(s0_4), .signal_1(s1_4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return full[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the STEP=1 instance; handshakes seen at a negedge complete on the next posedge.
  logic         prev_ov = 1'b0, prev_hold = 1'b0;
  logic [W-1:0] prev_prod = '0;
  int           busy_run = 0;
  item_t        it;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy) begin
        busy_run++;
        check("busy_outputs", {30'b0, out_valid, in_ready}, '0);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else begin
          check("latency", cyc - sb[0].acc_edge, N1);
          check("busy_cycles", busy_run, N1);
        end
      end
      if (out_valid && prev_hold) check("held_product", product, prev_prod);
      if (out_valid && !out_ready) check("in_ready_backpressure", in_ready, 1'b0);
      if (out_valid && out_ready && sb.size() > 0) begin
        it = sb.pop_front();
        check("product", product, it.exp);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{ref_mul(signal_0, signal_1), cyc + 1});
        busy_run = 0;
      end
      prev_hold = out_valid && !out_ready;
      prev_ov   = out_valid;
      prev_prod = product;
    end
  end

  // Monitor for the STEP=4 instance.
  logic  prev_ov4 = 1'b0;
  item_t it4;

  always @(negedge clk) begin
    if (!rst_n) prev_ov4 = 1'b0;
    else begin
      if (out_valid4 && !prev_ov4) begin
        if (sb4.size() == 0) check("step4_spurious", out_valid4, 1'b0);
        else check("step4_latency", cyc - sb4[0].acc_edge, N4);
      end
      if (out_valid4 && out_ready4 && sb4.size() > 0) begin
        it4 = sb4.pop_front();
        check("step4_product", product4, it4.exp);
      end
      if (in_valid4 && in_ready4) sb4.push_back('{ref_mul(s0_4, s1_4), cyc + 1});
      prev_ov4 = out_valid4;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    signal_0 = x;
    signal_1 = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue4(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    s0_4 = x;
    s1_4 = y;
    in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) check("step4_accept_timeout", in_ready4, 1'b1);
    @(posedge clk);
    #1 in_valid4 = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_product", product, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_reset", in_ready, 1'b1);

    // Basic product, then wrap vectors back to back (second accepted from DONE)
    out_ready = 1'b1;
    issue(32'd3, 32'd5);
    wait_out();
    @(posedge clk);
    #1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h1234_5678, 32'd9);
    wait_out();
    @(posedge clk);
    #1;

    // Backpressure: held in DONE while new operands are offered
    out_ready = 1'b0;
    issue(32'd3, 32'd5);
    wait_out();
    @(posedge clk);
    #1;
    signal_0 = 32'd7;
    signal_1 = 32'd7;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("backpressure_product", product, 32'd15);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    // Overlap: output and input handshakes on the same edge
    @(posedge clk);
    #1;
    issue(32'd1234, 32'd5678);
    wait_out();
    @(posedge clk);
    #1;
    signal_0  = 32'h0001_0000;
    signal_1  = 32'h0001_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("overlap_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("overlap_busy", busy, 1'b1);
    wait_out();
    @(posedge clk);
    #1;

    // Randomized traffic with random downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(rand_operand(), rand_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    @(negedge clk) rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of an operation
    issue(32'd3, 32'd5);
    wait_out();
    @(posedge clk);
    #1;
    issue(32'h1111, 32'h2222);
    repeat (17) @(posedge clk);
    #1 check("product_before_reset", product, 32'd15);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_product", product, '0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_in_ready", in_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_midreset", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_result", seen, 1'b0);

    // STEP=4 instance
    @(posedge clk);
    #1 out_ready4 = 1'b1;
    issue4(32'd7, 32'd6);
    issue4(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue4(32'h1234_5678, 32'd9);
    for (int i = 0; i < 8; i++) issue4(rand_operand(), rand_operand());
    n = 0;
    while (sb4.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("step4_drain_queue", sb4.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
